// File: rtl/f_fetch_stage.sv
// IF stage: program counter, next-PC selection, AdEL detection and IF/ID payload.
// Optional macro FETCH_RANGE_CHK_EN adds the [IM_LO, IM_HI] fetch-range check to AdEL.
module f_fetch_stage #(
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
    parameter logic [31:0] IM_LO      = 32'h0000_3000,
    parameter logic [31:0] IM_HI      = 32'h0000_6FFC
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        interrupt,
    input  logic        stall,
    input  logic        d_redirect,
    input  logic [31:0] d_target,
    input  logic        d_is_jump,
    input  logic        d_eret,
    input  logic [31:0] epc,
    output logic [31:0] i_addr,
    input  logic [31:0] i_inst,
    output logic [31:0] f_ir,
    output logic [31:0] f_pc,
    output logic [31:0] f_pc4,
    output logic [4:0]  f_exccode,
    output logic        f_bd
);

    localparam logic [4:0] EXC_NONE = 5'd0;
    localparam logic [4:0] EXC_ADEL = 5'd4;

`ifdef FETCH_RANGE_CHK_EN
    localparam bit RANGE_CHK_EN = 1'b1;
`else
    localparam bit RANGE_CHK_EN = 1'b0;
`endif

    logic [31:0] pc_reg;
    logic [31:0] pc_next;
    logic [31:0] pc_plus4;
    logic        misaligned;
    logic        out_of_range;
    logic        adel;
    logic        kill_slot;

    assign pc_plus4 = pc_reg + 32'd4;

    // Interrupt beats stall; stall beats eret/redirect because D re-presents them.
    always_comb begin
        pc_next = pc_plus4;
        if (interrupt) begin
            pc_next = HANDLER_PC;
        end else if (stall) begin
            pc_next = pc_reg;
        end else if (d_eret) begin
            pc_next = epc;
        end else if (d_redirect) begin
            pc_next = d_target;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_reg <= RESET_PC;
        end else begin
            pc_reg <= pc_next;
        end
    end

    assign misaligned   = |pc_reg[1:0];
    assign out_of_range = (pc_reg < IM_LO) || (pc_reg > IM_HI);
    assign adel         = misaligned || (RANGE_CHK_EN && out_of_range);

    // eret has no delay slot: whatever sits in F while eret is in D is squashed.
    assign kill_slot = d_eret;

    assign i_addr    = pc_reg;
    assign f_pc      = pc_reg;
    assign f_pc4     = pc_plus4;
    assign f_ir      = (kill_slot || adel) ? 32'h0 : i_inst;
    assign f_exccode = (!kill_slot && adel) ? EXC_ADEL : EXC_NONE;
    assign f_bd      = d_is_jump && !kill_slot;

endmodule

// File: tb/tb_f_fetch_stage.sv
// Bench for f_fetch_stage: table of per-cycle vectors checked through an expectation queue,
// followed by a hand-written reset-during-stall/redirect sequence.
module tb_f_fetch_stage;

`ifdef FETCH_RANGE_CHK_EN
    localparam bit RC = 1'b1;
`else
    localparam bit RC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset;
    logic        interrupt;
    logic        stall;
    logic        d_redirect;
    logic [31:0] d_target;
    logic        d_is_jump;
    logic        d_eret;
    logic [31:0] epc;
    logic [31:0] i_addr;
    logic [31:0] i_inst;
    logic [31:0] f_ir;
    logic [31:0] f_pc;
    logic [31:0] f_pc4;
    logic [4:0]  f_exccode;
    logic        f_bd;

    f_fetch_stage dut (
        .clk        (clk),
        .reset      (reset),
        .interrupt  (interrupt),
        .stall      (stall),
        .d_redirect (d_redirect),
        .d_target   (d_target),
        .d_is_jump  (d_is_jump),
        .d_eret     (d_eret),
        .epc        (epc),
        .i_addr     (i_addr),
        .i_inst     (i_inst),
        .f_ir       (f_ir),
        .f_pc       (f_pc),
        .f_pc4      (f_pc4),
        .f_exccode  (f_exccode),
        .f_bd       (f_bd)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        intr;
        logic        stall;
        logic        redir;
        logic [31:0] target;
        logic        is_jump;
        logic        eret;
        logic [31:0] epc;
        logic [31:0] exp_pc;
        logic        pass;
        logic [4:0]  exp_exc;
        logic        exp_bd;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] ir;
        logic [4:0]  exc;
        logic        bd;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    function automatic vec_t mk(logic intr, logic stl, logic redir, logic [31:0] target,
                                logic is_jump, logic eret, logic [31:0] e,
                                logic [31:0] exp_pc, logic pass, logic [4:0] exc, logic bd);
        vec_t v;
        v.intr = intr; v.stall = stl; v.redir = redir; v.target = target;
        v.is_jump = is_jump; v.eret = eret; v.epc = e;
        v.exp_pc = exp_pc; v.pass = pass; v.exp_exc = exc; v.exp_bd = bd;
        return v;
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s step %0d: got %h expected %h", name, idx, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected F outputs, then compare them.
    task automatic apply(input vec_t v, input int idx);
        exp_t e;
        exp_t got;
        logic [31:0] inst;
        inst       = $urandom;
        interrupt  = v.intr;
        stall      = v.stall;
        d_redirect = v.redir;
        d_target   = v.target;
        d_is_jump  = v.is_jump;
        d_eret     = v.eret;
        epc        = v.epc;
        i_inst     = inst;
        e.pc  = v.exp_pc;
        e.pc4 = v.exp_pc + 32'd4;
        e.ir  = v.pass ? inst : 32'h0;
        e.exc = v.exp_exc;
        e.bd  = v.exp_bd;
        sb.push_back(e);
        #1;
        got = sb.pop_front();
        chk("i_addr", idx, i_addr, got.pc);
        chk("f_pc", idx, f_pc, got.pc);
        chk("f_pc4", idx, f_pc4, got.pc4);
        chk("f_ir", idx, f_ir, got.ir);
        chk("f_exccode", idx, {27'd0, f_exccode}, {27'd0, got.exc});
        chk("f_bd", idx, {31'd0, f_bd}, {31'd0, got.bd});
        $display("[TB] step %0d pc=%h ir=%h exc=%0d bd=%0d", idx, f_pc, f_ir, f_exccode, f_bd);
    endtask

    initial begin
        #50000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        //               intr stl rdr target        jmp eret epc           exp_pc        pass exc            bd
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3004, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3008, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_300C, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_3100, 1, 0, 32'h0,         32'h0000_3010, 1, 5'd0,          1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3100, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_3020, 1, 0, 32'h0,         32'h0000_3104, 1, 5'd0,          1));
        vecs.push_back(mk(0, 1, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3020, 1, 5'd0,          0));
        vecs.push_back(mk(0, 1, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3020, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_3200, 0, 0, 32'h0,         32'h0000_3020, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_4190, 0, 0, 32'h0,         32'h0000_3200, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_3300, 1, 1, 32'h0000_3044, 32'h0000_4190, 0, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_3002, 0, 0, 32'h0,         32'h0000_3044, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3002, 0, 5'd4,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_7000, 1, 0, 32'h0,         32'h0000_3006, 0, 5'd4,          1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_7000, !RC, RC ? 5'd4 : 5'd0, 0));
        vecs.push_back(mk(1, 1, 1, 32'h0000_3300, 0, 1, 32'h0000_3044, 32'h0000_7004, 0, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_6FFC, 0, 0, 32'h0,         32'h0000_4180, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_6FFC, 1, 5'd0,          0));
        vecs.push_back(mk(0, 0, 1, 32'h0000_2FFC, 0, 0, 32'h0,         32'h0000_7000, !RC, RC ? 5'd4 : 5'd0, 0));
        vecs.push_back(mk(0, 0, 0, 32'h0,         1, 0, 32'h0,         32'h0000_2FFC, !RC, RC ? 5'd4 : 5'd0, 1));
        vecs.push_back(mk(0, 0, 0, 32'h0,         0, 0, 32'h0,         32'h0000_3000, 1, 5'd0,          0));

        reset = 1'b1; interrupt = 1'b0; stall = 1'b0; d_redirect = 1'b0; d_target = 32'h0;
        d_is_jump = 1'b0; d_eret = 1'b0; epc = 32'h0; i_inst = 32'h0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_i_addr", -1, i_addr, 32'h0000_3000);
        chk("reset_f_pc4", -1, f_pc4, 32'h0000_3004);
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
            @(negedge clk);
        end

        // Reset while a stall and a redirect are both pending: both are discarded.
        stall = 1'b1; d_redirect = 1'b1; d_target = 32'h0000_3500; reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        apply(mk(0, 0, 1, 32'h0000_3500, 0, 0, 32'h0, 32'h0000_3000, 1, 5'd0, 0), 100);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3000, 1, 5'd0, 0), 101);
        @(negedge clk);
        apply(mk(0, 0, 0, 32'h0, 0, 0, 32'h0, 32'h0000_3004, 1, 5'd0, 0), 102);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/f_fetch_stage.md
Name: f_fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the IF/ID register.
- Holds the program counter and drives the instruction-memory address.
- Detects fetch exceptions (AdEL) and selects the next PC from: sequential, branch/jump redirect from D, eret return, and interrupt/exception entry.
- Produces the instruction, fetch PC, PC+4, ExcCode and delay-slot flag that the IF/ID register latches.

Parameters:
- RESET_PC, 32'h0000_3000: PC value after reset.
- HANDLER_PC, 32'h0000_4180: exception/interrupt entry PC.
- IM_LO, 32'h0000_3000: lowest legal fetch address.
- IM_HI, 32'h0000_6FFC: highest legal fetch address, inclusive.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- interrupt  in  1  exception/interrupt taken this cycle (from CP0), redirects to HANDLER_PC
- stall  in  1  hazard stall; PC holds
- d_redirect  in  1  branch taken / j / jal / jr / jalr resolved in D this cycle
- d_target  in  32  redirect target from D
- d_is_jump  in  1  D-stage instruction is a branch or jump; current F instruction is its delay slot
- d_eret  in  1  eret in D this cycle
- epc  in  32  return address from CP0
- i_addr  out  32  instruction-memory address
- i_inst  in  32  instruction read from memory (combinational read)
- f_ir  out  32  instruction to IF/ID
- f_pc  out  32  fetch PC to IF/ID
- f_pc4  out  32  f_pc + 4
- f_exccode  out  5  0 = none, 4 = AdEL
- f_bd  out  1  fetched instruction is in a delay slot

Behaviour:
- Single state register: pc (32 bits).
  - Reset value RESET_PC.
  - Outputs are combinational from pc, so during and right after reset: i_addr = f_pc = 0x3000, f_pc4 = 0x3004.
- i_addr = pc; f_pc = pc; f_pc4 = pc + 32'd4 (wraps modulo 2^32, no carry out).
- Next-PC priority, evaluated at the clk edge, highest first:
  1. reset → RESET_PC
  2. interrupt → HANDLER_PC (overrides stall, eret and redirect)
  3. stall → pc holds (overrides eret and redirect; D re-presents them next cycle)
  4. d_eret → epc
  5. d_redirect → d_target
  6. otherwise → pc + 4
- d_eret and d_redirect asserted together: eret wins.
- AdEL is raised when pc[1:0] != 0, or when pc < IM_LO or pc > IM_HI (range check subject to the optional feature). On AdEL:
  - f_exccode = 5'd4
  - f_ir = 32'h0 (nop)
  - i_addr is still driven; memory returns don't-care and is ignored.
- Without an exception: f_exccode = 0, f_ir = i_inst.
- eret has no delay slot. While d_eret = 1, the current F output is killed:
  - f_ir = 0, f_exccode = 0, f_bd = 0
  - f_pc / f_pc4 are unchanged
- f_bd = d_is_jump, except that it is 0 when d_eret is killing the slot.
- The AdEL check is independent of f_bd: a delay-slot fetch can raise AdEL with f_bd = 1.
- Branch delay slot is architectural: after a taken redirect, the instruction at old pc + 4 is already in F and is not killed.
- Interrupt with stall: PC still loads HANDLER_PC. The downstream register flushes independently on interrupt.
- Reset mid-stall or mid-redirect: pc = RESET_PC on the next edge; all pending requests are discarded.

Optional Feature:
- Macro: FETCH_RANGE_CHK_EN.
- Defined: AdEL on misalignment OR pc outside [IM_LO, IM_HI].
- Undefined: AdEL only on pc[1:0] != 0; out-of-range aligned fetches pass i_inst through with f_exccode = 0.

Test Plan:
- Reset 2 cycles, then run 3 cycles with all controls low → i_addr 0x3000, 0x3004, 0x3008, 0x300C; f_exccode = 0; f_bd = 0.
- At pc = 0x3010: d_is_jump = 1 with d_redirect = 1, d_target = 0x3100 → same cycle f_bd = 1, f_ir = i_inst; next cycle i_addr = 0x3100.
- stall = 1 for 2 cycles at pc = 0x3020, with d_redirect also high → pc holds at 0x3020; after stall drops and redirect is still presented, pc = d_target.
- d_eret = 1, epc = 0x3044, at pc = 0x4190 → f_ir = 0, f_bd = 0, f_exccode = 0; next pc = 0x3044.
- d_redirect to 0x3002 → f_exccode = 4, f_ir = 0. With FETCH_RANGE_CHK_EN, redirect to 0x7000 → f_exccode = 4; without the macro → f_exccode = 0, f_ir = i_inst.
- interrupt = 1 together with stall = 1 and d_eret = 1 → next pc = 0x4180; f_pc4 = 0x4184.
